fetch_ctl: RTL and testbench

Fetch sequencer for the 16-bit simplecore front end. It drives the instruction-address register select (iAregCtl) and the PC step enable, runs the req/ack handshake to instruction memory, and holds one fetched instruction in a buffer until decode accepts it. It also arbitrates branch redirects from execute against outstanding fetches, and raises a sticky error if memory never acknowledges.

---
 rtl/simplecore_pkg.sv | 14 +
 rtl/fetch_ctl_if.sv | 35 +++
 rtl/fetch_ctl_satcnt.sv | 20 ++
 rtl/fetch_ctl.sv | 125 ++++++++++++
 tb/tb_fetch_ctl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/simplecore_pkg.sv
// Shared simplecore front-end definitions: fetch FSM state encoding and defaults.
package simplecore_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        REQ_GAP,
        ISSUE,
        ERROR
    } fetch_state_t;

    localparam int unsigned WAIT_MAX_DEFAULT = 64;

endpackage

// File: rtl/fetch_ctl_if.sv
// Fetch handshake bundle: instruction-memory req/ack, decode valid/ready, branch redirect.
interface fetch_ctl_if #(
    parameter int unsigned DATA_W = 16
);
    logic              imem_req;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic              inst_ready;
    logic              br_taken;
    logic              br_ready;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        output inst_valid,
        output inst_data,
        input  inst_ready,
        input  br_taken,
        output br_ready
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        input  inst_valid,
        input  inst_data,
        output inst_ready,
        output br_taken,
        input  br_ready
    );
endinterface

// File: rtl/fetch_ctl_satcnt.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module fetch_ctl_satcnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!nreset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctl.sv
// simplecore fetch sequencer: imem handshake, one-entry instruction buffer, redirects, ack timeout.
// Define FETCH_CTL_PERF_CNT_EN to build the fetch/flush performance counters.
module fetch_ctl
    import simplecore_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             nreset,
    fetch_ctl_if.master      bus,
    output logic             iAregCtl,
    output logic             pc_step,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned       WAIT_W    = $clog2(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    fetch_state_t      state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] inst_q;
    logic              in_fetch;
    logic              ack_fetch;
    logic              br_ready;
    logic              redirect;

    always_comb begin
        in_fetch  = (state == FETCH);
        ack_fetch = in_fetch & bus.imem_ack;
        br_ready  = ack_fetch | (state == ISSUE);
        redirect  = bus.br_taken & br_ready;
        iAregCtl  = redirect;
        pc_step   = ack_fetch & ~bus.br_taken;
    end

    assign bus.br_ready  = br_ready;
    assign bus.inst_data = inst_q;

    // Held at zero outside FETCH, so every entry into FETCH starts a fresh count.
    fetch_ctl_satcnt #(.W(WAIT_W)) u_wait_cnt (
        .clk    (clk),
        .nreset (nreset),
        .clr    (~in_fetch),
        .inc    (in_fetch & ~bus.imem_ack),
        .count  (wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state          <= IDLE;
            bus.imem_req   <= 1'b0;
            bus.inst_valid <= 1'b0;
            inst_q         <= '0;
            fetch_err      <= 1'b0;
        end else begin
            case (state)
                IDLE, REQ_GAP: begin
                    state        <= FETCH;
                    bus.imem_req <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        bus.imem_req <= 1'b0;
                        // A redirect on the ack cycle drops the word and re-requests from the new target.
                        if (bus.br_taken) begin
                            state <= REQ_GAP;
                        end else begin
                            state          <= ISSUE;
                            inst_q         <= bus.imem_rdata;
                            bus.inst_valid <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state        <= ERROR;
                        bus.imem_req <= 1'b0;
                        fetch_err    <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.br_taken) begin
                        state          <= REQ_GAP;
                        bus.inst_valid <= 1'b0;
                    end else if (bus.inst_ready) begin
                        state          <= FETCH;
                        bus.inst_valid <= 1'b0;
                        bus.imem_req   <= 1'b1;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state          <= IDLE;
                    bus.imem_req   <= 1'b0;
                    bus.inst_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CTL_PERF_CNT_EN
    fetch_ctl_satcnt #(.W(CNT_W)) u_fetch_cnt (
        .clk    (clk),
        .nreset (nreset),
        .clr    (1'b0),
        .inc    (ack_fetch),
        .count  (fetch_cnt)
    );

    fetch_ctl_satcnt #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .nreset (nreset),
        .clr    (1'b0),
        .inc    (redirect),
        .count  (flush_cnt)
    );
`else
    assign fetch_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctl.sv
// Self-checking bench for fetch_ctl: directed vectors plus an abstract per-cycle reference model.
module tb_fetch_ctl;

`ifdef FETCH_CTL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        nreset;
    logic        iareg;
    logic        pc_step;
    logic        ferr;
    logic [15:0] fcnt;
    logic [15:0] flcnt;
    logic [15:0] alu;
    logic [15:0] iaddr;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_ctl_if #(.DATA_W(16)) bus ();

    fetch_ctl #(
        .DATA_W   (16),
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus),
        .iAregCtl  (iareg),
        .pc_step   (pc_step),
        .fetch_err (ferr),
        .fetch_cnt (fcnt),
        .flush_cnt (flcnt)
    );

    always #5 clk = ~clk;

    // External instruction-address register driven by the DUT's select/step outputs.
    always @(posedge clk) begin
        if (!nreset)    iaddr <= 16'h0000;
        else if (iareg) iaddr <= alu;
        else            iaddr <= iaddr + {15'd0, pc_step};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the front end is either requesting, holding one word, idle, or dead.
    bit          m_known = 1'b0;
    bit          m_req, m_have, m_err;
    int          m_wait, m_fcnt, m_flcnt;
    logic [15:0] m_data;
    bit          e_brr, e_iar, e_step;

    always @(negedge clk) begin
        if (m_known) begin
            e_brr  = (m_req && bus.imem_ack) || m_have;
            e_iar  = bus.br_taken && e_brr;
            e_step = m_req && bus.imem_ack && !bus.br_taken;
            check("m_imem_req",   bus.imem_req,   m_req);
            check("m_inst_valid", bus.inst_valid, m_have);
            check("m_inst_data",  bus.inst_data,  m_data);
            check("m_fetch_err",  ferr,           m_err);
            check("m_br_ready",   bus.br_ready,   e_brr);
            check("m_iAregCtl",   iareg,          e_iar);
            check("m_pc_step",    pc_step,        e_step);
            check("m_fetch_cnt",  fcnt,  PERF ? m_fcnt  : 0);
            check("m_flush_cnt",  flcnt, PERF ? m_flcnt : 0);
        end
        if (!nreset) begin
            m_known = 1'b1;
            m_req = 0; m_have = 0; m_err = 0;
            m_wait = 0; m_fcnt = 0; m_flcnt = 0; m_data = 16'h0000;
        end else if (m_known) begin
            if (e_iar && m_flcnt < 65535) m_flcnt++;
            if (m_err) begin
                m_err = 1'b1;
            end else if (m_have) begin
                if (bus.br_taken) m_have = 0;
                else if (bus.inst_ready) begin m_have = 0; m_req = 1; m_wait = 0; end
            end else if (m_req) begin
                if (bus.imem_ack) begin
                    if (m_fcnt < 65535) m_fcnt++;
                    m_req = 0;
                    if (!bus.br_taken) begin m_have = 1; m_data = bus.imem_rdata; end
                end else if (m_wait + 1 >= WAIT_MAX) begin
                    m_err = 1; m_req = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_req = 1; m_wait = 0;
            end
        end
    end

    // Inputs change only just after a rising edge; literal probes look just after the falling edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    initial begin
        nreset = 0; alu = 16'h0000;
        bus.imem_ack = 0; bus.imem_rdata = 16'h0000; bus.inst_ready = 0; bus.br_taken = 0;
        step(); step();
        nreset = 1;
        probe();
        check("rst_req", bus.imem_req, 0);   check("rst_valid", bus.inst_valid, 0);
        check("rst_data", bus.inst_data, 0); check("rst_err", ferr, 0);
        check("rst_brr", bus.br_ready, 0);   check("rst_step", pc_step, 0);
        check("rst_iar", iareg, 0);          check("rst_fcnt", fcnt, 0);
        check("rst_flcnt", flcnt, 0);

        step();
        probe(); check("f1_req", bus.imem_req, 1); check("f1_brr", bus.br_ready, 0);
        step(); bus.imem_ack = 1; bus.imem_rdata = 16'hA5C3;
        probe(); check("ack_step", pc_step, 1); check("ack_brr", bus.br_ready, 1);
        check("ack_valid", bus.inst_valid, 0);
        step(); bus.imem_ack = 0;
        probe(); check("iss_valid", bus.inst_valid, 1); check("iss_data", bus.inst_data, 16'hA5C3);
        check("iss_req", bus.imem_req, 0); check("iss_addr", iaddr, 1);

        for (int i = 0; i < 5; i++) begin
            step();
            bus.imem_ack = (i == 2); bus.imem_rdata = 16'hFFFF;
            probe();
            check("hold_req", bus.imem_req, 0); check("hold_step", pc_step, 0);
            check("hold_data", bus.inst_data, 16'hA5C3); check("hold_addr", iaddr, 1);
            check("hold_valid", bus.inst_valid, 1);
        end

        step(); bus.imem_ack = 0; bus.br_taken = 1; bus.inst_ready = 1; alu = 16'h0040;
        probe(); check("issbr_brr", bus.br_ready, 1); check("issbr_iar", iareg, 1);
        check("issbr_step", pc_step, 0);
        step(); bus.br_taken = 0; bus.inst_ready = 0;
        probe(); check("gap_valid", bus.inst_valid, 0); check("gap_req", bus.imem_req, 0);
        check("gap_brr", bus.br_ready, 0); check("gap_addr", iaddr, 16'h0040);
        check("gap_flcnt", flcnt, PERF ? 1 : 0);
        step();
        probe(); check("refetch_req", bus.imem_req, 1);

        step(); nreset = 0;
        probe(); check("midrst_req", bus.imem_req, 1);
        step(); nreset = 1;
        probe(); check("postrst_req", bus.imem_req, 0); check("postrst_fcnt", fcnt, 0);
        check("postrst_flcnt", flcnt, 0);
        step(); bus.br_taken = 1; alu = 16'h0080;
        probe(); check("br1_brr", bus.br_ready, 0); check("br1_iar", iareg, 0);
        step();
        probe(); check("br2_brr", bus.br_ready, 0);
        step(); bus.imem_ack = 1; bus.imem_rdata = 16'h5A5A;
        probe(); check("br3_brr", bus.br_ready, 1); check("br3_iar", iareg, 1);
        check("br3_step", pc_step, 0);
        step(); bus.imem_ack = 0; bus.br_taken = 0;
        probe(); check("disc_valid", bus.inst_valid, 0); check("disc_req", bus.imem_req, 0);
        check("disc_addr", iaddr, 16'h0080); check("disc_fcnt", fcnt, PERF ? 1 : 0);
        check("disc_flcnt", flcnt, PERF ? 1 : 0);
        step();

        for (int i = 0; i < WAIT_MAX; i++) begin
            probe(); check("to_req", bus.imem_req, 1); check("to_err", ferr, 0);
            step();
        end
        bus.br_taken = 1; alu = 16'h0099; bus.imem_ack = 1; bus.imem_rdata = 16'h1111;
        probe(); check("err_flag", ferr, 1); check("err_req", bus.imem_req, 0);
        check("err_brr", bus.br_ready, 0); check("err_iar", iareg, 0);
        check("err_valid", bus.inst_valid, 0);
        step();
        probe(); check("err_addr", iaddr, 16'h0080); check("err_fcnt", fcnt, PERF ? 1 : 0);
        check("err_flcnt", flcnt, PERF ? 1 : 0); check("err_sticky", ferr, 1);
        step(); nreset = 0; bus.br_taken = 0; bus.imem_ack = 0;
        probe(); check("err_prerst", ferr, 1);
        step(); nreset = 1;
        probe(); check("clr_err", ferr, 0); check("clr_req", bus.imem_req, 0);
        step();
        probe(); check("restart_req", bus.imem_req, 1);

        step(); bus.imem_ack = 1; bus.imem_rdata = 16'h1234;
        probe(); check("r6_step", pc_step, 1);
        step(); bus.imem_ack = 0;
        probe(); check("r6_valid", bus.inst_valid, 1); check("r6_data", bus.inst_data, 16'h1234);
        step(); nreset = 0; bus.inst_ready = 1;
        probe(); check("r6_prerst", bus.inst_valid, 1);
        step(); nreset = 1; bus.inst_ready = 0;
        probe(); check("r6_valid0", bus.inst_valid, 0); check("r6_req0", bus.imem_req, 0);
        check("r6_data0", bus.inst_data, 0); check("r6_fcnt0", fcnt, 0);
        check("r6_flcnt0", flcnt, 0);

        for (int i = 0; i < 80; i++) begin
            step();
            nreset         = ((i % 20) != 19);
            bus.imem_ack   = ($urandom_range(0, 2) != 0);
            bus.imem_rdata = 16'($urandom);
            bus.inst_ready = ($urandom_range(0, 1) != 0);
            bus.br_taken   = ($urandom_range(0, 3) == 0);
            alu            = 16'($urandom);
        end
        step(); nreset = 1; bus.imem_ack = 0; bus.br_taken = 0; bus.inst_ready = 0;
        probe();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
